uart_bridge: RTL and testbench
==============================

UART_BRIDGE -- requirements
Module: uart_bridge

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, clk cycles per serial bit (50 MHz / 115200).
REQ-002 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port uartOp_i  input  4  memory op for the data register at 0xBFD003F8, `MEM_* encoding from defines.v.
REQ-005 SHALL have port uart_storeData_i  input  32  store data; only [7:0] used.
REQ-006 SHALL have port stall_i  input  1  pipeline stall; ops are ignored while high.
REQ-007 SHALL have port rxd  input  1  asynchronous serial receive line.
REQ-008 SHALL have port txd  output  1  serial transmit line, idle high.
REQ-009 SHALL have port uart_load_data_o  output  32  {24'b0, RX holding byte}.
REQ-010 SHALL have port dataReady  output  1  RX holding byte valid, status bit 1 at 0xBFD003FC.
REQ-011 SHALL have port writeReady  output  1  TX can accept a byte, status bit 0 at 0xBFD003FC.

Function
REQ-012 Op accepted = uartOp_i != `MEM_NOP and stall_i == 0 in that cycle; one accept per cycle.
REQ-013 Store accept = `MEM_SB/`MEM_SH/`MEM_SW accepted; load accept = `MEM_LB/`MEM_LBU/`MEM_LH/`MEM_LHU/`MEM_LW accepted.
REQ-014 Store accept with writeReady=1 SHALL enqueue uart_storeData_i[7:0]; with writeReady=0 the byte SHALL be dropped, no state change.
REQ-015 uart_load_data_o SHALL be combinational from the holding register, valid in the same cycle as the load, 32'h0 when dataReady=0.
REQ-016 Load accept with dataReady=1 SHALL clear dataReady at the next edge; with dataReady=0 no state change.
REQ-017 TX FSM states IDLE, START, DATA, STOP; each non-IDLE state holds its line level for exactly CLKS_PER_BIT cycles.
REQ-018 IDLE->START when a byte is queued, on the edge after enqueue; txd=0 in START; DATA sends bits LSB first (8 bits, 3-bit index); txd=1 in STOP; STOP->START directly if another byte is queued, else IDLE.
REQ-019 Frame length 10*CLKS_PER_BIT cycles; back-to-back frames SHALL have no idle gap.
REQ-020 rxd SHALL pass a 2-flop synchronizer before use.
REQ-021 RX FSM states IDLE, START, DATA, STOP; IDLE->START on synchronized falling edge; START re-samples at CLKS_PER_BIT/2 and returns to IDLE if high (glitch).
REQ-022 DATA samples each bit at CLKS_PER_BIT after the previous sample point, LSB first; STOP samples once more.
REQ-023 Stop bit 1: byte SHALL be written to the holding register and dataReady set; stop bit 0: frame discarded, dataReady unchanged.
REQ-024 New byte while dataReady=1 SHALL overwrite the holding register (overrun, no flag); if in the same cycle as a load accept, the new byte wins and dataReady stays 1.
REQ-025 Baud counters SHALL be wide enough for CLKS_PER_BIT-1 and SHALL reload to 0 at each bit boundary.

Reset
REQ-026 rst high at a clock edge SHALL force: txd=1, dataReady=0, writeReady=1, uart_load_data_o=0, both FSMs IDLE, counters 0, TX queue empty.
REQ-027 Reset mid-frame SHALL abort the frame immediately; txd reads 1 from the cycle after the reset edge.

Configuration
REQ-028 Macro UART_TX_FIFO_EN defined: TX queue is a 4-entry FIFO (2-bit pointers, wrap-around, separate full flag); writeReady = !full; enqueue and dequeue in the same cycle on a full FIFO SHALL both succeed.
REQ-029 Macro UART_TX_FIFO_EN undefined: TX queue is one holding register; writeReady = 1 only when the TX FSM is IDLE and nothing is queued.

Verification (CLKS_PER_BIT=4)
REQ-030 Store SW 0x00000155 -> txd low 4 cycles, then 1,0,1,0,1,0,1,0 each 4 cycles, then high 4 cycles; writeReady high again after the frame.
REQ-031 Drive rxd frame 0x3C with valid stop -> dataReady=1, uart_load_data_o=0x0000003C; LW accept -> dataReady=0 next cycle.
REQ-032 rxd frame 0xA5 with stop bit 0 -> dataReady stays 0; 1-cycle low glitch on rxd -> no frame received.
REQ-033 With FIFO: 5 SB stores 0x41..0x45 back-to-back -> writeReady=0 after the 4th, 0x45 dropped, 0x41..0x44 sent with no idle gaps; without FIFO: 2nd store dropped.
REQ-034 rst asserted mid-TX-DATA -> txd=1, writeReady=1, no further bits; SW with stall_i=1 -> no frame sent.

Source files
------------

// File: rtl/uart_bridge.sv
// Memory-mapped UART with a 1-byte RX holding register, a TX queue and TX/RX bit FSMs.
// Optional macro UART_TX_FIFO_EN selects a 4-entry TX FIFO instead of a single TX holding register.
// Ports:
//   clk, rst (sync, active-high)
//   uartOp_i, uart_storeData_i, stall_i : pipeline access to the data register
//   rxd, txd                            : serial lines, idle high
//   uart_load_data_o                    : {24'b0, RX byte}
//   dataReady, writeReady               : status bits 1 and 0
// The `MEM_* opcodes get defaults here unless defines.v was read earlier.
`ifndef MEM_NOP
`define MEM_NOP 4'd0
`define MEM_LB  4'd1
`define MEM_LBU 4'd2
`define MEM_LH  4'd3
`define MEM_LHU 4'd4
`define MEM_LW  4'd5
`define MEM_SB  4'd6
`define MEM_SH  4'd7
`define MEM_SW  4'd8
`endif

module uart_bridge #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  uartOp_i,
  input  logic [31:0] uart_storeData_i,
  input  logic        stall_i,
  input  logic        rxd,
  output logic        txd,
  output logic [31:0] uart_load_data_o,
  output logic        dataReady,
  output logic        writeReady
);

  localparam int CW =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int HALF =
    (CLKS_PER_BIT >= 2) ? CLKS_PER_BIT / 2 : 1;
  localparam logic [CW-1:0] BIT_END =
    CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(HALF - 1);

  typedef enum logic [1:0] {
    S_IDLE, S_START, S_DATA, S_STOP
  } uart_st_t;

  // Op decode
  logic is_st, is_ld, st_acc, ld_acc;

  always_comb begin
    is_st = 1'b0;
    is_ld = 1'b0;
    case (uartOp_i)
      `MEM_SB, `MEM_SH, `MEM_SW: is_st = 1'b1;
      `MEM_LB, `MEM_LBU, `MEM_LH,
      `MEM_LHU, `MEM_LW: is_ld = 1'b1;
      default: ;
    endcase
  end

  assign st_acc = is_st & ~stall_i;
  assign ld_acc = is_ld & ~stall_i;

  // TX state
  uart_st_t       tx_st, tx_st_n;
  logic [CW-1:0]  tx_cnt, tx_cnt_n;
  logic [2:0]     tx_idx, tx_idx_n;
  logic           tx_end, pop, enq, more;
  logic           q_ne;
  logic [7:0]     q_head;

  assign tx_end = (tx_cnt == BIT_END);
  // The head byte stays queued until its stop bit
  // completes, so the queue accounts for the byte
  // currently on the wire.
  assign pop = (tx_st == S_STOP) && tx_end;

`ifdef UART_TX_FIFO_EN
  logic [7:0] fifo_q [4];
  logic [1:0] wp, rp;
  logic       full;

  assign q_ne       = full || (wp != rp);
  assign q_head     = fifo_q[rp];
  assign writeReady = ~full;
  // A pop frees the slot the write lands in.
  assign enq        = st_acc && (~full || pop);
  // Queue still non-empty after this cycle's pop.
  assign more = full || (rp + 2'd1 != wp) || enq;

  always_ff @(posedge clk) begin
    if (enq) fifo_q[wp] <= uart_storeData_i[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp   <= '0;
      rp   <= '0;
      full <= 1'b0;
    end else begin
      if (enq) wp <= wp + 2'd1;
      if (pop) rp <= rp + 2'd1;
      if (enq && !pop)
        full <= (wp + 2'd1 == rp);
      else if (pop && !enq)
        full <= 1'b0;
    end
  end
`else
  logic [7:0] hold_q;
  logic       hold_v;

  assign q_ne       = hold_v;
  assign q_head     = hold_q;
  assign writeReady = (tx_st == S_IDLE) && !hold_v;
  assign enq        = st_acc && writeReady;
  assign more       = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_v <= 1'b0;
      hold_q <= '0;
    end else if (enq) begin
      hold_v <= 1'b1;
      hold_q <= uart_storeData_i[7:0];
    end else if (pop) begin
      hold_v <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_st  <= S_IDLE;
      tx_cnt <= '0;
      tx_idx <= '0;
    end else begin
      tx_st  <= tx_st_n;
      tx_cnt <= tx_cnt_n;
      tx_idx <= tx_idx_n;
    end
  end

  always_comb begin
    tx_st_n  = tx_st;
    tx_cnt_n = tx_cnt;
    tx_idx_n = tx_idx;
    txd      = 1'b1;
    case (tx_st)
      S_IDLE: begin
        tx_cnt_n = '0;
        tx_idx_n = '0;
        if (q_ne) tx_st_n = S_START;
      end
      S_START: begin
        txd = 1'b0;
        if (tx_end) begin
          tx_cnt_n = '0;
          tx_idx_n = '0;
          tx_st_n  = S_DATA;
        end else begin
          tx_cnt_n = tx_cnt + 1'b1;
        end
      end
      S_DATA: begin
        txd = q_head[tx_idx];
        if (tx_end) begin
          tx_cnt_n = '0;
          if (tx_idx == 3'd7)
            tx_st_n = S_STOP;
          else
            tx_idx_n = tx_idx + 3'd1;
        end else begin
          tx_cnt_n = tx_cnt + 1'b1;
        end
      end
      S_STOP: begin
        txd = 1'b1;
        if (tx_end) begin
          tx_cnt_n = '0;
          tx_st_n  = more ? S_START : S_IDLE;
        end else begin
          tx_cnt_n = tx_cnt + 1'b1;
        end
      end
      default: tx_st_n = S_IDLE;
    endcase
  end

  // RX path
  uart_st_t      rx_st, rx_st_n;
  logic [CW-1:0] rx_cnt, rx_cnt_n;
  logic [2:0]    rx_idx, rx_idx_n;
  logic [7:0]    rx_sh, rx_sh_n, rx_hold;
  logic          rx_s1, rx_s2, rx_prev;
  logic          rx_fall, rx_ok;

  assign rx_fall = rx_prev & ~rx_s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rxd;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_st     <= S_IDLE;
      rx_cnt    <= '0;
      rx_idx    <= '0;
      rx_sh     <= '0;
      rx_hold   <= '0;
      dataReady <= 1'b0;
    end else begin
      rx_st  <= rx_st_n;
      rx_cnt <= rx_cnt_n;
      rx_idx <= rx_idx_n;
      rx_sh  <= rx_sh_n;
      if (rx_ok) rx_hold <= rx_sh;
      // A fresh byte outranks a concurrent load.
      if (rx_ok)
        dataReady <= 1'b1;
      else if (ld_acc)
        dataReady <= 1'b0;
    end
  end

  always_comb begin
    rx_st_n  = rx_st;
    rx_cnt_n = rx_cnt;
    rx_idx_n = rx_idx;
    rx_sh_n  = rx_sh;
    rx_ok    = 1'b0;
    case (rx_st)
      S_IDLE: begin
        rx_cnt_n = '0;
        rx_idx_n = '0;
        if (rx_fall) rx_st_n = S_START;
      end
      S_START: begin
        if (rx_cnt == HALF_END) begin
          rx_cnt_n = '0;
          rx_st_n  = rx_s2 ? S_IDLE : S_DATA;
        end else begin
          rx_cnt_n = rx_cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (rx_cnt == BIT_END) begin
          rx_cnt_n = '0;
          rx_sh_n  = {rx_s2, rx_sh[7:1]};
          if (rx_idx == 3'd7)
            rx_st_n = S_STOP;
          else
            rx_idx_n = rx_idx + 3'd1;
        end else begin
          rx_cnt_n = rx_cnt + 1'b1;
        end
      end
      S_STOP: begin
        if (rx_cnt == BIT_END) begin
          rx_cnt_n = '0;
          rx_st_n  = S_IDLE;
          rx_ok    = rx_s2;
        end else begin
          rx_cnt_n = rx_cnt + 1'b1;
        end
      end
      default: rx_st_n = S_IDLE;
    endcase
  end

  assign uart_load_data_o =
    dataReady ? {24'b0, rx_hold} : 32'h0;

endmodule

// File: tb/tb_uart_bridge.sv
// Directed self-checking bench for uart_bridge.
// Runs with CLKS_PER_BIT=4; follows UART_TX_FIFO_EN.
module tb_uart_bridge;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SW  = 4'd8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  uartOp_i = OP_NOP;
  logic [31:0] uart_storeData_i = '0;
  logic        stall_i = 1'b0;
  logic        rxd = 1'b1;
  logic        txd;
  logic [31:0] uart_load_data_o;
  logic        dataReady;
  logic        writeReady;

  int n_chk  = 0;
  int n_fail = 0;

  uart_bridge #(.CLKS_PER_BIT(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .uartOp_i         (uartOp_i),
    .uart_storeData_i (uart_storeData_i),
    .stall_i          (stall_i),
    .rxd              (rxd),
    .txd              (txd),
    .uart_load_data_o (uart_load_data_o),
    .dataReady        (dataReady),
    .writeReady       (writeReady)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [3:0] op,
                       input logic [31:0] d);
    uartOp_i = op;
    uart_storeData_i = d;
    tick;
    uartOp_i = OP_NOP;
  endtask

  // Wait for a start bit, then record n txd samples.
  task automatic cap(input int n,
                     output logic [159:0] v,
                     output int lat);
    v = '0;
    lat = 0;
    while (txd && lat < 30) begin
      tick;
      lat++;
    end
    chk("tx_start_seen", txd, 0);
    for (int k = 0; k < n; k++) begin
      v[k] = txd;
      tick;
    end
  endtask

  task automatic quiet(input string tag, input int n);
    int lows;
    lows = 0;
    for (int i = 0; i < n; i++) begin
      if (!txd) lows++;
      tick;
    end
    chk(tag, lows, 0);
  endtask

  task automatic send_rx(input logic [7:0] b,
                         input logic stop);
    rxd = 1'b0;
    repeat (4) tick;
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (4) tick;
    end
    rxd = stop;
    repeat (4) tick;
    rxd = 1'b1;
  endtask

  task automatic wait_dr(input int n);
    for (int i = 0; i < n && !dataReady; i++) tick;
  endtask

  logic [159:0] v;
  int           lat;
  logic [4:0]   wr_seen;

  initial begin
    tick;
    tick;
    chk("rst_txd", txd, 1);
    chk("rst_dr", dataReady, 0);
    chk("rst_wr", writeReady, 1);
    chk("rst_load", uart_load_data_o, 0);
    rst = 1'b0;
    tick;

    // Load with nothing received
    uartOp_i = OP_LW;
    #1;
    chk("ld_empty", uart_load_data_o, 0);
    tick;
    uartOp_i = OP_NOP;
    chk("ld_empty_dr", dataReady, 0);

    // TX 0x55 frame, one nibble per bit
    store(OP_SW, 32'h0000_0155);
    chk("tx_wr_busy", writeReady, 0);
    cap(40, v, lat);
    chk("tx_lat", lat, 1);
    chk("tx_55", v[39:0], 40'hF0F0F0F0F0);
    chk("tx_wr_done", writeReady, 1);
    chk("tx_idle", txd, 1);

    // RX good frame then load
    send_rx(8'h3C, 1'b1);
    wait_dr(20);
    chk("rx_dr", dataReady, 1);
    chk("rx_3c", uart_load_data_o, 32'h3C);
    uartOp_i = OP_LW;
    #1;
    chk("rx_ld_same", uart_load_data_o, 32'h3C);
    tick;
    uartOp_i = OP_NOP;
    chk("rx_ld_clr", dataReady, 0);
    chk("rx_ld_zero", uart_load_data_o, 0);

    // Bad stop bit
    send_rx(8'hA5, 1'b0);
    repeat (20) tick;
    chk("rx_badstop", dataReady, 0);

    // One-cycle glitch
    rxd = 1'b0;
    tick;
    rxd = 1'b1;
    repeat (30) tick;
    chk("rx_glitch", dataReady, 0);

    // Overrun overwrites the held byte
    send_rx(8'h3C, 1'b1);
    wait_dr(20);
    send_rx(8'h81, 1'b1);
    repeat (10) tick;
    chk("rx_ovr_dr", dataReady, 1);
    chk("rx_ovr", uart_load_data_o, 32'h81);
    store(OP_LW, 32'h0);
    chk("rx_ovr_clr", dataReady, 0);

    // Stalled store is ignored
    stall_i = 1'b1;
    store(OP_SW, 32'h0000_0012);
    stall_i = 1'b0;
    chk("stall_wr", writeReady, 1);
    quiet("stall_quiet", 50);

    // Back-to-back stores
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          uartOp_i = OP_SB;
          uart_storeData_i = 32'h41 + i;
          tick;
          wr_seen[i] = writeReady;
        end
        uartOp_i = OP_NOP;
      end
`ifdef UART_TX_FIFO_EN
      cap(160, v, lat);
`else
      cap(40, v, lat);
`endif
    join
`ifdef UART_TX_FIFO_EN
    chk("fifo_wr3", wr_seen[2], 1);
    chk("fifo_wr4", wr_seen[3], 0);
    chk("fifo_wr5", wr_seen[4], 0);
    chk("fifo_41", v[39:0], 40'hF0F00000F0);
    chk("fifo_42", v[79:40], 40'hF0F0000F00);
    chk("fifo_43", v[119:80], 40'hF0F0000FF0);
    chk("fifo_44", v[159:120], 40'hF0F000F000);
`else
    chk("hold_wr1", wr_seen[0], 0);
    chk("hold_wr2", wr_seen[1], 0);
    chk("hold_41", v[39:0], 40'hF0F00000F0);
`endif
    chk("b2b_wr_done", writeReady, 1);
    quiet("b2b_drop", 60);

    // Reset in the middle of DATA
    store(OP_SW, 32'h0000_0000);
    repeat (9) tick;
    chk("rst_mid_data", txd, 0);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rst_mid_txd", txd, 1);
    chk("rst_mid_wr", writeReady, 1);
    quiet("rst_mid_quiet", 50);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
